// File: rtl/ila_pkg.sv
// ila_pkg -- shared types and constants for the ILA capture block.
//   state_t     : capture controller states
//   TRIG_LEVEL  : trig_edge value selecting level-match triggering
//   TRIG_RISING : trig_edge value selecting rising-match triggering
package ila_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic TRIG_LEVEL  = 1'b0;
  localparam logic TRIG_RISING = 1'b1;

endpackage

// File: rtl/ila_ram.sv
// ila_ram -- simple dual-port sample buffer, one write port and one
// registered read port, DEPTH x W, written to infer block RAM.
// Ports:
//   clk      : clock for both ports
//   rst      : synchronous active-high reset of the read register only
//   we       : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable, loads the read register
//   rd_addr  : read address
//   rd_data  : registered read data (one cycle after rd_en)
module ila_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register reset is supported by block RAM output latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ila_capture.sv
// ila_capture -- integrated logic analyzer capture engine. Records probe
// every cycle while busy into a circular buffer, keeps PRETRIG samples of
// history before the trigger and DEPTH-PRETRIG-1 samples after it.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   probe       : sample written each capturing cycle
//   trig_value  : trigger compare value
//   trig_mask   : 1 = bit takes part in the compare
//   trig_edge   : 0 = level match, 1 = rising match
//   arm, abort  : one-cycle start / cancel pulses (abort wins)
//   rd_en       : readout request, rd_addr = offset from oldest sample
//   rd_data     : readout sample, valid one cycle after rd_en (rd_valid)
//   busy        : high in PRE, ARMED, POST
//   triggered   : high from trigger until next arm/abort/reset
//   done        : high in DONE
//   trig_addr   : physical RAM index of the trigger sample
module ila_capture
  import ila_pkg::*;
#(
  parameter int PROBE_W = 64,
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PROBE_W-1:0]       probe,
  input  logic [PROBE_W-1:0]       trig_value,
  input  logic [PROBE_W-1:0]       trig_mask,
  input  logic                     trig_edge,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [PROBE_W-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] trig_addr
);

  localparam int AW       = $clog2(DEPTH);
  localparam int POST_LEN = DEPTH - PRETRIG - 1;
  // Last-cycle counter values; when a phase has zero length the value is
  // never compared, so the wrapped constant is harmless.
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_LEN - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] cnt;
  logic          match;
  logic          match_q;
  logic          trigger;
  logic [AW-1:0] rd_phys;

  assign match   = ((probe ^ trig_value) & trig_mask) == '0;
  assign trigger = (trig_edge == TRIG_RISING) ? (match & ~match_q) : match;

  assign busy = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign done = (state == S_DONE);

  // Oldest kept sample sits PRETRIG slots behind the trigger; the AW-bit
  // arithmetic wraps naturally around the circular buffer.
  assign rd_phys = trig_addr - PRE_OFS + rd_addr;

  // Capture controller. match_q runs in every state so rising-edge mode
  // sees the probe history from before ARMED (including the arm cycle).
  always_ff @(posedge clk) begin
    match_q <= match;
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      cnt       <= '0;
      match_q   <= 1'b0;
      trig_addr <= '0;
      triggered <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      triggered <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            cnt       <= '0;
            triggered <= 1'b0;
            state     <= (PRETRIG == 0) ? S_ARMED : S_PRE;
          end
        end
        S_PRE: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (cnt == PRE_LAST) begin
            cnt   <= '0;
            state <= S_ARMED;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        S_ARMED: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (trigger) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            cnt       <= '0;
            state     <= (POST_LEN == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_ptr <= wr_ptr + AW'(1);
          if (cnt == POST_LAST) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  ila_ram #(
    .W     (PROBE_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (busy),
    .wr_addr (wr_ptr),
    .wr_data (probe),
    .rd_en   (rd_en),
    .rd_addr (rd_phys),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_ila_capture.sv
// tb_ila_capture -- self-checking bench for ila_capture with PROBE_W=8,
// DEPTH=16, PRETRIG=4. Expected behaviour comes from a sample-stream
// model: trigger index is the first sample at or after PRETRIG that
// matches, done follows DEPTH-PRETRIG-1 samples later, and the readout
// window is the DEPTH samples starting PRETRIG before the trigger.
module tb_ila_capture;
  import ila_pkg::*;

  localparam int PROBE_W  = 8;
  localparam int DEPTH    = 16;
  localparam int PRETRIG  = 4;
  localparam int POST_LEN = DEPTH - PRETRIG - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   probe;
  logic [7:0]   trig_value;
  logic [7:0]   trig_mask;
  logic         trig_edge;
  logic         arm;
  logic         abort;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         busy;
  logic         triggered;
  logic         done;
  logic [3:0]   trig_addr;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [7:0]   stim [256];
  int           t_exp;
  int           d_exp;
  bit           done_reached;
  logic [7:0]   r_tv;
  logic [7:0]   r_tm;
  logic [7:0]   r_pre;
  logic         r_edge;

  ila_capture #(
    .PROBE_W (PROBE_W),
    .DEPTH   (DEPTH),
    .PRETRIG (PRETRIG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .probe      (probe),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .trig_edge  (trig_edge),
    .arm        (arm),
    .abort      (abort),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit model_match(input logic [7:0] p, input logic [7:0] tv,
                                     input logic [7:0] tm);
    return ((p ^ tv) & tm) == 8'h00;
  endfunction

  // First capture-cycle index that fires the trigger, or -1 within n samples.
  function automatic int model_trigger(input logic [7:0] pre, input logic [7:0] tv,
                                       input logic [7:0] tm, input logic edge_mode,
                                       input int n);
    bit prev;
    bit cur;
    prev = model_match(pre, tv, tm);
    for (int s = 0; s < n; s++) begin
      cur = model_match(stim[s], tv, tm);
      if (s >= PRETRIG && (edge_mode ? (cur && !prev) : cur)) return s;
      prev = cur;
    end
    return -1;
  endfunction

  task automatic fillCounter();
    for (int i = 0; i < 256; i++) stim[i] = 8'(i);
  endtask

  task automatic fillConst(input logic [7:0] v);
    for (int i = 0; i < 256; i++) stim[i] = v;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
  endtask

  // Arm, then feed stim[0..n-1] one per cycle, checking status each cycle.
  task automatic applyStimulus(input logic [7:0] pre, input logic [7:0] tv,
                               input logic [7:0] tm, input logic edge_mode,
                               input int n, input int arm_at);
    bit trig_now;
    bit done_now;
    t_exp = model_trigger(pre, tv, tm, edge_mode, n);
    d_exp = (t_exp >= 0) ? t_exp + POST_LEN : -1;
    done_reached = 1'b0;
    probe      = pre;
    trig_value = tv;
    trig_mask  = tm;
    trig_edge  = edge_mode;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < n; i++) begin
      probe = stim[i];
      arm   = (i == arm_at);
      tick();
      arm = 1'b0;
      trig_now = (t_exp >= 0) && (i >= t_exp);
      done_now = (d_exp >= 0) && (i >= d_exp);
      checkOutput("triggered", 32'(triggered), 32'(trig_now));
      checkOutput("done", 32'(done), 32'(done_now));
      checkOutput("busy", 32'(busy), 32'(!done_now));
      if (t_exp >= 0 && i == t_exp)
        checkOutput("trig_addr", 32'(trig_addr), 32'(t_exp % DEPTH));
      if (done_now) begin
        done_reached = 1'b1;
        break;
      end
    end
  endtask

  task automatic readBack();
    for (int k = 0; k < DEPTH; k++) begin
      rd_en   = 1'b1;
      rd_addr = 4'(k);
      tick();
      checkOutput("rd_valid", 32'(rd_valid), 32'(1));
      checkOutput("rd_data", 32'(rd_data), 32'(stim[t_exp - PRETRIG + k]));
    end
    rd_en = 1'b0;
    tick();
    checkOutput("rd_valid_idle", 32'(rd_valid), 32'(0));
  endtask

  task automatic abortCapture();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_triggered", 32'(triggered), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
  endtask

  task automatic finishCapture();
    if (done_reached) readBack();
    else abortCapture();
  endtask

  initial begin
    rst        = 1'b1;
    probe      = 8'h00;
    trig_value = 8'h00;
    trig_mask  = 8'h00;
    trig_edge  = TRIG_LEVEL;
    arm        = 1'b0;
    abort      = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = 4'h0;
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_triggered", 32'(triggered), 32'(0));
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'(0));
    checkOutput("reset_rd_data", 32'(rd_data), 32'(0));
    checkOutput("reset_trig_addr", 32'(trig_addr), 32'(0));
    rst = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'(0));

    // Level trigger on sample 10.
    fillCounter();
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 40, -1);
    finishCapture();

    // Mask zero: trigger on first ARMED sample.
    applyStimulus(8'hFF, 8'h55, 8'h00, TRIG_LEVEL, 40, -1);
    finishCapture();

    // Constant probe: rising mode never fires, level mode fires at sample 4.
    fillConst(8'h0A);
    applyStimulus(8'h0A, 8'h0A, 8'hFF, TRIG_RISING, 40, -1);
    finishCapture();
    applyStimulus(8'h0A, 8'h0A, 8'hFF, TRIG_LEVEL, 40, -1);
    finishCapture();

    // Trigger after the write pointer has wrapped many times.
    fillCounter();
    applyStimulus(8'hFF, 8'h64, 8'hFF, TRIG_LEVEL, 130, -1);
    finishCapture();

    // Abort in POST, then a clean repeat of the level-trigger capture.
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 14, -1);
    abortCapture();
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 40, -1);
    finishCapture();

    // arm and abort together in IDLE stay idle.
    abortCapture();
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    checkOutput("arm_abort_busy", 32'(busy), 32'(0));
    tick();
    checkOutput("arm_abort_busy_later", 32'(busy), 32'(0));

    // arm while ARMED is ignored; capture continues unchanged.
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 40, 7);
    finishCapture();

    // Reset mid-capture abandons it and clears trig_addr.
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 8, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid_busy", 32'(busy), 32'(0));
    checkOutput("rst_mid_triggered", 32'(triggered), 32'(0));
    checkOutput("rst_mid_trig_addr", 32'(trig_addr), 32'(0));
    applyStimulus(8'hFF, 8'h0A, 8'hFF, TRIG_LEVEL, 40, -1);
    finishCapture();

    // Randomized captures.
    for (int r = 0; r < 6; r++) begin
      fillRandom();
      r_tv   = 8'($urandom);
      r_pre  = 8'($urandom);
      r_edge = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       r_tm = 8'h03;
        1:       r_tm = 8'h07;
        default: r_tm = 8'h0F;
      endcase
      applyStimulus(r_pre, r_tv, r_tm, r_edge, 200, -1);
      finishCapture();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ila_capture.md
ILA_CAPTURE -- requirements
Module: ila_capture

Interface
REQ-001 SHALL have parameter PROBE_W, 64, probe sample width in bits.
REQ-002 SHALL have parameter DEPTH, 1024, capture depth in samples (power of two, >= 4).
REQ-003 SHALL have parameter PRETRIG, 256, samples kept before trigger (0 <= PRETRIG < DEPTH).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port probe  input  PROBE_W  sample captured every cycle while capturing.
REQ-007 SHALL have port trig_value  input  PROBE_W  trigger compare value.
REQ-008 SHALL have port trig_mask  input  PROBE_W  1 = bit participates in compare.
REQ-009 SHALL have port trig_edge  input  1  0 = level match, 1 = rising match.
REQ-010 SHALL have port arm  input  1  one-cycle start pulse.
REQ-011 SHALL have port abort  input  1  one-cycle cancel pulse.
REQ-012 SHALL have port rd_en  input  1  readout request.
REQ-013 SHALL have port rd_addr  input  log2(DEPTH)  logical offset from oldest sample.
REQ-014 SHALL have port rd_data  output  PROBE_W  readout sample.
REQ-015 SHALL have port rd_valid  output  1  rd_data valid.
REQ-016 SHALL have port busy  output  1  high in PRE, ARMED, POST.
REQ-017 SHALL have port triggered  output  1  high from trigger until next arm/abort/reset.
REQ-018 SHALL have port done  output  1  high in DONE.
REQ-019 SHALL have port trig_addr  output  log2(DEPTH)  physical RAM index of trigger sample.

Function
REQ-020 SHALL implement states IDLE, PRE, ARMED, POST, DONE.
REQ-021 arm in IDLE or DONE SHALL clear wr_ptr and triggered, enter PRE (ARMED if PRETRIG=0); arm in PRE/ARMED/POST SHALL be ignored.
REQ-022 In PRE, ARMED, POST each cycle SHALL write probe to RAM[wr_ptr], wr_ptr increments modulo DEPTH (wrap).
REQ-023 PRE SHALL last exactly PRETRIG cycles, trigger ignored, then enter ARMED.
REQ-024 match = ((probe ^ trig_value) & trig_mask) == 0; trig_mask=0 SHALL match every cycle.
REQ-025 match_q SHALL register match every cycle in every state; trigger = match when trig_edge=0, match & !match_q when trig_edge=1.
REQ-026 Trigger in ARMED SHALL set trig_addr = wr_ptr of that cycle's sample, set triggered, enter POST.
REQ-027 POST SHALL write exactly DEPTH-PRETRIG-1 further samples then enter DONE; no writes in IDLE or DONE.
REQ-028 Readout: rd_en with rd_addr=k SHALL return RAM[(trig_addr - PRETRIG + k) mod DEPTH] one cycle later with rd_valid=1; rd_valid=0 otherwise.
REQ-029 Readout SHALL be accepted in any state; content is defined only in DONE.
REQ-030 abort SHALL force IDLE from any state, clear triggered; abort with arm same cycle: abort wins, state IDLE.
REQ-031 Unsigned modulo-DEPTH pointer arithmetic SHALL be used; no overflow flags.

Reset
REQ-032 rst SHALL set state IDLE, wr_ptr 0, counters 0, match_q 0, trig_addr 0, triggered/done/busy/rd_valid 0; rd_data 0.
REQ-033 RAM contents SHALL NOT be reset; rst mid-capture SHALL abandon capture identically to abort.

Structure
REQ-034 Package ila_pkg SHALL hold the state enum and trigger-mode constants.
REQ-035 Sub-module ila_ram SHALL be a simple dual-port RAM (1 write, 1 registered read), DEPTH x PROBE_W, inferable as block RAM.

Verification (PROBE_W=8, DEPTH=16, PRETRIG=4; probe = counter 0,1,2... from first capture cycle)
REQ-036 Level, trig_value=0x0A, mask=0xFF -> trigger on sample 10, trig_addr=10, done after sample 21, read k=0..15 returns 6..21.
REQ-037 mask=0x00 -> trigger on first ARMED sample 4, read 0..15 returns 0..15.
REQ-038 probe held 0x0A before and after arm, trig_value=0x0A: edge mode never triggers; level mode triggers at sample 4.
REQ-039 Trigger at sample 100 (wrap) -> trig_addr=4, read 0..15 returns 96..111 (mod 256).
REQ-040 abort during POST -> IDLE, done=0, triggered=0; subsequent arm repeats REQ-036 result.
REQ-041 arm and abort same cycle in IDLE -> stays IDLE, busy=0; arm during ARMED ignored, wr_ptr continues.
